mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waiting for mem_ack before abort.
REQ-003 SHALL have ports: clk in 1, system clock; rst in 1, reset is synchronous and active-high.
REQ-004 SHALL have fetch ports: if_req in 1; if_addr in XLEN; if_gnt out 1; if_rdata out XLEN; if_valid out 1; if_err out 1.
REQ-005 SHALL have data ports: d_req in 1; d_we in 1; d_funct3 in 3 (LB/LH/LW/LBU/LHU, SB/SH/SW encodings); d_addr in XLEN; d_wdata in XLEN; d_gnt out 1; d_rdata out XLEN; d_valid out 1; d_err out 1.
REQ-006 SHALL have memory ports: mem_req out 1; mem_we out 1; mem_addr out XLEN; mem_be out 4; mem_wdata out XLEN; mem_ack in 1; mem_rdata in XLEN.

Function
REQ-007 SHALL share one memory port between fetch and data requesters using FSM states IDLE, IF_BUSY, D_BUSY, ERR.
REQ-008 SHALL assert if_gnt/d_gnt combinationally, only in IDLE, for the selected requester; at most one gnt per cycle.
REQ-009 Requesters SHALL hold req and inputs stable until gnt; arbiter SHALL capture address/funct3/wdata/we in the gnt cycle.
REQ-010 Default arbitration SHALL be fixed priority, data over fetch, when both req are high in IDLE.
REQ-011 SHALL move IDLE->IF_BUSY or IDLE->D_BUSY on grant; mem_req SHALL be high from the cycle after gnt until the mem_ack cycle inclusive.
REQ-012 mem_addr SHALL be {captured addr[XLEN-1:2], 2'b00}; fetch SHALL use mem_we=0, mem_be=4'b1111.
REQ-013 Data mem_be SHALL be base << addr[1:0], base B=0001, H=0011, W=1111; mem_wdata SHALL be wdata << 8*addr[1:0].
REQ-014 Data access SHALL be misaligned when H/HU with addr[0]=1, or W with addr[1:0]!=0; misaligned or unknown funct3 SHALL go IDLE->ERR with no mem_req.
REQ-015 ERR SHALL pulse d_valid=1, d_err=1, d_rdata=0 for one cycle, then return to IDLE.
REQ-016 On mem_ack in *_BUSY, SHALL register result: next cycle pulse if_valid or d_valid for exactly one cycle, return to IDLE in that same edge.
REQ-017 Load result SHALL be (mem_rdata >> 8*addr[1:0]) masked to B/H/W, sign-extended for LB/LH, zero-extended for LBU/LHU; stores SHALL return d_rdata=0.
REQ-018 Fetch result if_rdata SHALL be mem_rdata unmodified.
REQ-019 SHALL count busy cycles; if mem_ack absent for TIMEOUT cycles, SHALL drop mem_req, pulse valid with err=1, rdata=0, return to IDLE.
REQ-020 mem_ack outside *_BUSY SHALL be ignored.
REQ-021 Minimum latency gnt->valid SHALL be 2 cycles with mem_ack on first mem_req cycle; back-to-back grant allowed in the cycle after valid.
REQ-022 rdata outputs SHALL hold last value between valid pulses.

Reset
REQ-023 On rst, state SHALL be IDLE; mem_req, mem_we, mem_be, if_valid, d_valid, if_err, d_err, timeout counter SHALL be 0; mem_addr, mem_wdata, if_rdata, d_rdata SHALL be 0.
REQ-024 rst mid-transaction SHALL abort it: no valid pulse, mem_req low after the reset edge, late mem_ack ignored.
REQ-025 Round-robin pointer (when compiled in) SHALL reset to favour data.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: simultaneous requests SHALL be granted round-robin, the requester not served by the last grant wins.
REQ-027 MEM_ARB_RR_EN undefined: fixed data-over-fetch priority per REQ-010; no pointer register.

Verification
REQ-028 LW addr 0x100, mem_rdata=0x11223344, ack on first cycle -> mem_be=1111, d_valid 2 cycles after gnt, d_rdata=0x11223344.
REQ-029 LB addr 0x103, mem_rdata=0x80FFFFFF -> mem_be=1000, d_rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-030 SH addr 0x202, wdata=0x0000BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF0000, d_valid, d_err=0.
REQ-031 LW addr 0x101 -> no mem_req, d_valid=1, d_err=1 one cycle after gnt; LH addr 0x102 -> normal access.
REQ-032 if_req and d_req both held for 4 transactions -> default: d,d,d,d then fetch; with MEM_ARB_RR_EN: d,if,d,if.
REQ-033 Fetch with mem_ack never asserted, TIMEOUT=4 -> mem_req drops after 4 cycles, if_valid=1, if_err=1; rst during D_BUSY -> no d_valid, IDLE next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one memory port between fetch and data requesters;
//               data-over-fetch priority, or round-robin with MEM_ARB_RR_EN.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_valid,
    output logic            if_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [2:0]      d_funct3,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_valid,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TO_LAST    = CW'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2,
        ERR     = 2'd3
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      off_q;
    logic [2:0]      funct3_q;
    logic            we_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [3:0]      mem_be_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic            if_valid_q;
    logic            if_err_q;
    logic [XLEN-1:0] if_rdata_q;
    logic            d_valid_q;
    logic            d_err_q;
    logic [XLEN-1:0] d_rdata_q;

    logic            pick_d;
    logic [3:0]      be_base;
    logic            f3_ok;
    logic            misalign;
    logic            d_bad;
    logic [3:0]      d_be;
    logic [XLEN-1:0] d_wdata_sh;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] d_result;

    // Arbitration: the only state differing between the two builds is the
    // "last grant went to data" flag used to alternate under contention.
`ifdef MEM_ARB_RR_EN
    logic last_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else if (d_gnt) begin
            last_d_q <= 1'b1;
        end else if (if_gnt) begin
            last_d_q <= 1'b0;
        end
    end

    assign pick_d = d_req && !(if_req && last_d_q);
`else
    assign pick_d = d_req;
`endif

    assign d_gnt  = (state_q == IDLE) && pick_d;
    assign if_gnt = (state_q == IDLE) && if_req && !pick_d;

    always_comb begin
        be_base  = 4'b0000;
        f3_ok    = 1'b0;
        misalign = 1'b0;
        case (d_funct3)
            3'b000: begin be_base = 4'b0001; f3_ok = 1'b1; end
            3'b001: begin be_base = 4'b0011; f3_ok = 1'b1; misalign = d_addr[0]; end
            3'b010: begin be_base = 4'b1111; f3_ok = 1'b1; misalign = |d_addr[1:0]; end
            3'b100: begin be_base = 4'b0001; f3_ok = !d_we; end
            3'b101: begin be_base = 4'b0011; f3_ok = !d_we; misalign = d_addr[0]; end
            default: ;
        endcase
    end

    assign d_bad      = !f3_ok || misalign;
    assign d_be       = be_base << d_addr[1:0];
    assign d_wdata_sh = d_wdata << {d_addr[1:0], 3'b000};

    assign rd_shift = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_val = rd_shift;
        case (funct3_q)
            3'b000:  load_val = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_val = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
            default: load_val = rd_shift;
        endcase
    end

    assign d_result = we_q ? '0 : load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
            we_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            // valid/err are single-cycle pulses; rdata holds until next result
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (d_gnt) begin
                        off_q    <= d_addr[1:0];
                        funct3_q <= d_funct3;
                        we_q     <= d_we;
                        if (d_bad) begin
                            state_q   <= ERR;
                            d_valid_q <= 1'b1;
                            d_err_q   <= 1'b1;
                            d_rdata_q <= '0;
                        end else begin
                            state_q     <= D_BUSY;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= d_we;
                            mem_addr_q  <= d_addr & ALIGN_MASK;
                            mem_be_q    <= d_be;
                            mem_wdata_q <= d_wdata_sh;
                        end
                    end else if (if_gnt) begin
                        state_q     <= IF_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr & ALIGN_MASK;
                        mem_be_q    <= 4'b1111;
                        mem_wdata_q <= '0;
                    end
                end
                IF_BUSY: begin
                    if (mem_ack) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        if_valid_q <= 1'b1;
                        if_rdata_q <= mem_rdata;
                    end else if (cnt_q == TO_LAST) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        if_valid_q <= 1'b1;
                        if_err_q   <= 1'b1;
                        if_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                D_BUSY: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        d_valid_q <= 1'b1;
                        d_rdata_q <= d_result;
                    end else if (cnt_q == TO_LAST) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        d_valid_q <= 1'b1;
                        d_err_q   <= 1'b1;
                        d_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ERR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire
